// File: rtl/arb_mux_n_pkg.sv
// Shared types and helpers for the arb_mux_n arbitrating multiplexer.
package arb_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_t;

  // Index width that never collapses to zero bits, even for N=2.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_mux_n_if.sv
// Channel-side and consumer-side handshake bundle for arb_mux_n.
// The in_lock vector exists only when ARB_LOCK_EN is defined.
interface arb_mux_n_if
  import arb_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 64
) ();

  localparam int IW = idx_width(N);

  // Valid/ready: a beat moves on any edge where valid && ready are both high;
  // a source never waits for ready before raising valid, and data is only
  // meaningful while valid is high.
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_sel;
  logic           out_ready;

`ifdef ARB_LOCK_EN
  logic [N-1:0]   in_lock;

  modport master (
    output in_valid, in_data, in_lock, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, in_lock, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
`endif

endinterface

// File: rtl/arb_mux_n_rr_arbiter.sv
// One-hot arbiter: round-robin from an internal pointer, or fixed lowest-index
// priority. The pointer moves to the slot after the winner when i_advance is high.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int        N    = 8,
  parameter arb_mode_t MODE = ARB_RR,
  localparam int       IW   = idx_width(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  i_valid,
  input  logic          i_advance,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] w_ptr;

  generate
    if (MODE == ARB_RR) begin : g_rr
      logic [IW-1:0] r_ptr;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_ptr <= '0;
        end else if (i_advance) begin
          r_ptr <= (int'(o_idx) == N - 1) ? '0 : o_idx + 1'b1;
        end
      end

      assign w_ptr = r_ptr;
    end else begin : g_fixed
      assign w_ptr = '0;
    end
  endgenerate

  // Scan from the farthest slot back to the pointer so the nearest requester
  // overwrites the others and wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(w_ptr) + k;
      if (j >= N) j = j - N;
      if (i_valid[j]) begin
        o_grant    = '0;
        o_grant[j] = 1'b1;
        o_idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// N-channel arbitrating mux with a one-deep registered output stage.
// Define ARB_LOCK_EN to add the in_lock vector that pins the grant to one channel.
module arb_mux_n
  import arb_pkg::*;
#(
  parameter int        N    = 8,
  parameter int        W    = 64,
  parameter arb_mode_t MODE = ARB_RR
) (
  input  logic         clk,
  input  logic         reset_n,
  arb_mux_n_if.slave   bus
);

  localparam int IW = idx_width(N);

  logic [N-1:0]  w_req;
  logic [N-1:0]  w_grant;
  logic [IW-1:0] w_idx;
  logic [W-1:0]  w_sel_data;
  logic          w_any;
  logic          w_load;
  logic          w_xfer;
  logic          w_advance;

  logic          r_out_valid;
  logic [W-1:0]  r_out_data;
  logic [IW-1:0] r_out_sel;

`ifdef ARB_LOCK_EN
  logic          r_locked;
  logic [IW-1:0] r_lock_idx;
  logic [N-1:0]  w_lock_mask;

  // While locked only the owning channel may win; everyone else is masked off.
  assign w_lock_mask = N'(1) << r_lock_idx;
  assign w_req       = r_locked ? (bus.in_valid & w_lock_mask) : bus.in_valid;
  assign w_advance   = w_xfer && !bus.in_lock[w_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_locked   <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_xfer) begin
      r_locked   <= bus.in_lock[w_idx];
      r_lock_idx <= w_idx;
    end
  end
`else
  assign w_req     = bus.in_valid;
  assign w_advance = w_xfer;
`endif

  rr_arbiter #(
    .N    (N),
    .MODE (MODE)
  ) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_valid   (w_req),
    .i_advance (w_advance),
    .o_grant   (w_grant),
    .o_idx     (w_idx)
  );

  // Gating with reset_n keeps every in_ready low while reset is held.
  assign w_any      = |w_req;
  assign w_load     = reset_n && (!r_out_valid || bus.out_ready);
  assign w_xfer     = w_load && w_any;
  assign w_sel_data = bus.in_data[int'(w_idx)*W +: W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_load) begin
      r_out_valid <= w_any;
      if (w_any) begin
        r_out_data <= w_sel_data;
        r_out_sel  <= w_idx;
      end
    end
  end

  assign bus.in_ready  = w_grant & {N{w_load}};
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;

endmodule

// File: tb/tb_arb_mux_n.sv
// Bench for arb_mux_n: a round-robin and a fixed-priority instance share one
// stimulus stream; directed scenarios plus randomized traffic against a model.
module tb_arb_mux_n;
  import arb_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           tb_reset_n;
  logic [N-1:0]   tb_valid;
  logic [N*W-1:0] tb_data;
  logic           tb_ready;
`ifdef ARB_LOCK_EN
  logic [N-1:0]   tb_lock;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, index 0 = round-robin instance, 1 = fixed instance.
  logic         m_valid[2];
  logic [W-1:0] m_data[2];
  logic [1:0]   m_sel[2];
  int           m_ptr[2];
  logic         m_lk[2];
  int           m_lkch[2];

  always #5 clk = ~clk;

  arb_mux_n_if #(.N(N), .W(W)) bus_rr ();
  arb_mux_n_if #(.N(N), .W(W)) bus_fx ();

  assign bus_rr.in_valid  = tb_valid;
  assign bus_rr.in_data   = tb_data;
  assign bus_rr.out_ready = tb_ready;
  assign bus_fx.in_valid  = tb_valid;
  assign bus_fx.in_data   = tb_data;
  assign bus_fx.out_ready = tb_ready;
`ifdef ARB_LOCK_EN
  assign bus_rr.in_lock   = tb_lock;
  assign bus_fx.in_lock   = tb_lock;
`endif

  arb_mux_n #(.N(N), .W(W), .MODE(ARB_RR)) u_rr (
    .clk     (clk),
    .reset_n (tb_reset_n),
    .bus     (bus_rr.slave)
  );

  arb_mux_n #(.N(N), .W(W), .MODE(ARB_FIXED)) u_fx (
    .clk     (clk),
    .reset_n (tb_reset_n),
    .bus     (bus_fx.slave)
  );

  // Winner = requesting channel at the smallest circular distance from the
  // pointer (round-robin) or the smallest index (fixed); -1 when nobody asks.
  function automatic int pick(input int md);
    logic [N-1:0] v;
    int best;
    int bestd;
    v = tb_valid;
    if (m_lk[md]) v = tb_valid & (4'b0001 << m_lkch[md]);
    best  = -1;
    bestd = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        int d;
        d = (md == 0) ? (i - m_ptr[md] + N) % N : i;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [N-1:0] exp_ready(input int md);
    int g;
    g = pick(md);
    if (tb_reset_n && (!m_valid[md] || tb_ready) && g >= 0) return 4'b0001 << g;
    return 4'b0000;
  endfunction

  task automatic model_reset();
    for (int md = 0; md < 2; md++) begin
      m_valid[md] = 1'b0;
      m_data[md]  = '0;
      m_sel[md]   = '0;
      m_ptr[md]   = 0;
      m_lk[md]    = 1'b0;
      m_lkch[md]  = 0;
    end
  endtask

  task automatic model_step(input int md);
    int   g;
    logic lkb;
    g   = pick(md);
    lkb = 1'b0;
`ifdef ARB_LOCK_EN
    if (g >= 0) lkb = tb_lock[g];
`endif
    if (!m_valid[md] || tb_ready) begin
      if (g >= 0) begin
        m_valid[md] = 1'b1;
        m_data[md]  = tb_data[g*W +: W];
        m_sel[md]   = 2'(g);
        m_lk[md]    = lkb;
        m_lkch[md]  = g;
        if (!lkb) m_ptr[md] = (g + 1) % N;
      end else begin
        m_valid[md] = 1'b0;
      end
    end
  endtask

  // Advance both models and the DUTs by one clock; returns #1 after the edge.
  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [N-1:0] v, input logic r);
    tb_valid = v;
    tb_ready = r;
  endtask

  task automatic do_reset();
    tb_reset_n = 1'b0;
    tb_valid   = '0;
    tb_ready   = 1'b0;
`ifdef ARB_LOCK_EN
    tb_lock    = '0;
`endif
    model_reset();
    @(posedge clk);
    #1;
    tb_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    tb_reset_n = 1'b0;
    tb_valid   = '0;
    tb_ready   = 1'b0;
    tb_data    = '0;
`ifdef ARB_LOCK_EN
    tb_lock    = '0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({bus_rr.out_valid, bus_rr.out_data, bus_rr.out_sel} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_init: got v=%b d=%h s=%0d want all zero",
               bus_rr.out_valid, bus_rr.out_data, bus_rr.out_sel);
    end
    tb_reset_n = 1'b1;
    tb_data    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    set_in(4'b1111, 1'b1);
    tick();
    n_tests++;
    if (bus_rr.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_load: out_valid got %b want 1", bus_rr.out_valid);
    end
    tb_reset_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if ({bus_rr.out_valid, bus_rr.out_data, bus_rr.out_sel, bus_rr.in_ready} !== 15'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b d=%h s=%0d rdy=%b want all zero",
               bus_rr.out_valid, bus_rr.out_data, bus_rr.out_sel, bus_rr.in_ready);
    end
    @(posedge clk);
    #1;
    tb_reset_n = 1'b1;
    #1;
    n_tests++;
    if (bus_rr.in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_first_grant: in_ready got %b want 0001", bus_rr.in_ready);
    end
    tick();
    n_tests++;
    if (bus_rr.out_sel !== 2'd0 || bus_rr.out_data !== 8'hA0) begin
      n_fail++;
      $display("FAIL reset_first_word: got s=%0d d=%h want s=0 d=a0",
               bus_rr.out_sel, bus_rr.out_data);
    end
  endtask

  task automatic test_rr_fairness();
    do_reset();
    tb_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    set_in(4'b1111, 1'b1);
    for (int k = 0; k < 10; k++) begin
      #1;
      n_tests++;
      if (bus_rr.in_ready !== (4'b0001 << (k % N)) || bus_fx.in_ready !== 4'b0001) begin
        n_fail++;
        $display("FAIL rr_ready[%0d]: rr got %b fx got %b", k, bus_rr.in_ready, bus_fx.in_ready);
      end
      tick();
      n_tests++;
      if (bus_rr.out_valid !== 1'b1 || bus_rr.out_sel !== 2'(k % N) ||
          bus_rr.out_data !== 8'(8'hA0 + k % N)) begin
        n_fail++;
        $display("FAIL rr_seq[%0d]: got v=%b s=%0d d=%h want v=1 s=%0d",
                 k, bus_rr.out_valid, bus_rr.out_sel, bus_rr.out_data, k % N);
      end
    end
  endtask

  task automatic test_fixed();
    do_reset();
    tb_data = {8'hF3, 8'hF2, 8'hF1, 8'hF0};
    set_in(4'b1010, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_tests++;
      if (bus_fx.in_ready !== 4'b0010) begin
        n_fail++;
        $display("FAIL fixed_ready[%0d]: got %b want 0010", k, bus_fx.in_ready);
      end
      tick();
      n_tests++;
      if (bus_fx.out_sel !== 2'd1 || bus_fx.out_data !== 8'hF1) begin
        n_fail++;
        $display("FAIL fixed_sel[%0d]: got s=%0d d=%h want s=1 d=f1",
                 k, bus_fx.out_sel, bus_fx.out_data);
      end
    end
    set_in(4'b1000, 1'b1);
    #1;
    n_tests++;
    if (bus_fx.in_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL fixed_drop: got %b want 1000", bus_fx.in_ready);
    end
    tick();
    n_tests++;
    if (bus_fx.out_sel !== 2'd3) begin
      n_fail++;
      $display("FAIL fixed_ch3: out_sel got %0d want 3", bus_fx.out_sel);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    tb_data = {8'h33, 8'hC2, 8'h5C, 8'h00};
    set_in(4'b0010, 1'b1);
    tick();
    set_in(4'b0100, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_tests++;
      if (bus_rr.in_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_ready[%0d]: got %b want 0000", k, bus_rr.in_ready);
      end
      tick();
      n_tests++;
      if (bus_rr.out_valid !== 1'b1 || bus_rr.out_data !== 8'h5C || bus_rr.out_sel !== 2'd1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h s=%0d want v=1 d=5c s=1",
                 k, bus_rr.out_valid, bus_rr.out_data, bus_rr.out_sel);
      end
    end
    set_in(4'b0100, 1'b1);
    #1;
    n_tests++;
    if (bus_rr.in_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL bp_release: in_ready got %b want 0100", bus_rr.in_ready);
    end
    tick();
    n_tests++;
    if (bus_rr.out_data !== 8'hC2 || bus_rr.out_sel !== 2'd2) begin
      n_fail++;
      $display("FAIL bp_refill: got d=%h s=%0d want d=c2 s=2", bus_rr.out_data, bus_rr.out_sel);
    end
    set_in(4'b0000, 1'b1);
    tick();
    n_tests++;
    if (bus_rr.out_valid !== 1'b0 || bus_rr.out_data !== 8'hC2 || bus_rr.out_sel !== 2'd2) begin
      n_fail++;
      $display("FAIL drain_hold: got v=%b d=%h s=%0d want v=0 d=c2 s=2",
               bus_rr.out_valid, bus_rr.out_data, bus_rr.out_sel);
    end
  endtask

  task automatic test_wrap();
    logic [N-1:0] pats[5];
    logic [N-1:0] want[5];
    pats = '{4'b0100, 4'b0001, 4'b0011, 4'b1000, 4'b1111};
    want = '{4'b0100, 4'b0001, 4'b0010, 4'b1000, 4'b0001};
    do_reset();
    tb_data = {8'h73, 8'h72, 8'h71, 8'h70};
    for (int k = 0; k < 5; k++) begin
      set_in(pats[k], 1'b1);
      #1;
      n_tests++;
      if (bus_rr.in_ready !== want[k]) begin
        n_fail++;
        $display("FAIL wrap[%0d]: in_ready got %b want %b", k, bus_rr.in_ready, want[k]);
      end
      tick();
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    logic [N-1:0] pats[7];
    logic [N-1:0] lks[7];
    logic [N-1:0] want[7];
    pats = '{4'b0001, 4'b0011, 4'b0011, 4'b0001, 4'b0011, 4'b0101, 4'b0001};
    lks  = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    want = '{4'b0001, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0100, 4'b0001};
    do_reset();
    tb_data = {8'h43, 8'h42, 8'h41, 8'h40};
    for (int k = 0; k < 7; k++) begin
      set_in(pats[k], 1'b1);
      tb_lock = lks[k];
      #1;
      n_tests++;
      if (bus_rr.in_ready !== want[k]) begin
        n_fail++;
        $display("FAIL lock[%0d]: in_ready got %b want %b", k, bus_rr.in_ready, want[k]);
      end
      tick();
    end
    tb_lock = '0;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      tb_valid = 4'($urandom_range(15));
      tb_ready = ($urandom_range(3) != 0);
      tb_data  = $urandom;
`ifdef ARB_LOCK_EN
      tb_lock  = ($urandom_range(2) == 0) ? 4'($urandom_range(15)) : 4'b0000;
`endif
      #1;
      n_tests++;
      if (bus_rr.in_ready !== exp_ready(0) || bus_fx.in_ready !== exp_ready(1)) begin
        n_fail++;
        $display("FAIL rand_ready[%0d]: rr got %b want %b, fx got %b want %b",
                 k, bus_rr.in_ready, exp_ready(0), bus_fx.in_ready, exp_ready(1));
      end
      tick();
      n_tests++;
      if (bus_rr.out_valid !== m_valid[0] || bus_rr.out_data !== m_data[0] ||
          bus_rr.out_sel !== m_sel[0]) begin
        n_fail++;
        $display("FAIL rand_rr_out[%0d]: got v=%b d=%h s=%0d want v=%b d=%h s=%0d", k,
                 bus_rr.out_valid, bus_rr.out_data, bus_rr.out_sel, m_valid[0], m_data[0], m_sel[0]);
      end
      n_tests++;
      if (bus_fx.out_valid !== m_valid[1] || bus_fx.out_data !== m_data[1] ||
          bus_fx.out_sel !== m_sel[1]) begin
        n_fail++;
        $display("FAIL rand_fx_out[%0d]: got v=%b d=%h s=%0d want v=%b d=%h s=%0d", k,
                 bus_fx.out_valid, bus_fx.out_data, bus_fx.out_sel, m_valid[1], m_data[1], m_sel[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_fixed();
    test_backpressure();
    test_wrap();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_mux_n.md
Name: arb_mux_n

Overview:
- Parametrised successor to the datapath select muxes: N-channel, W-bit-wide multiplexer with its own arbitration and a registered output stage.
- Each channel presents data with a valid/ready handshake. The block picks one requesting channel per cycle, either round-robin or fixed-priority, and registers the chosen word.
- Sits between multiple requesters (e.g. fetch, load/store, debug) and a single shared consumer port in the CPU datapath.

Parameters:
- N, 8, number of input channels (N >= 2).
- W, 64, data width per channel in bits.
- MODE, ARB_RR, arbitration mode from arb_pkg: ARB_RR (round-robin) or ARB_FIXED (lowest index wins).

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  N  per-channel request.
- in_data  input  N*W  flattened channel data; channel i occupies bits [i*W +: W].
- in_ready  output  N  per-channel accept; a transfer occurs on channel i when in_valid[i] && in_ready[i].
- out_valid  output  1  output register holds a word.
- out_data  output  W  registered selected data.
- out_sel  output  $clog2(N)  index of the channel that supplied out_data.
- out_ready  input  1  consumer accept; transfer when out_valid && out_ready.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer = 0, so channel 0 has highest priority.
  - in_ready=0 while reset_n is low.
- Load condition: load = !out_valid || out_ready. The output register can accept a new word when it is empty or being drained in the same cycle.
- Grant: combinational one-hot grant[N] over in_valid.
  - ARB_FIXED: lowest set index wins.
  - ARB_RR: search starts at the pointer and wraps modulo N; first set index wins.
- in_ready[i] = grant[i] && load. At most one in_ready is high per cycle; all are 0 when no channel is valid.
- On a transfer from channel g:
  - Next cycle: out_data = in_data[g], out_sel = g, out_valid = 1.
  - Latency is exactly 1 cycle from input transfer to out_valid.
  - ARB_RR only: pointer <= (g+1) mod N, wrapping from N-1 to 0. The pointer changes only on a transfer.
- On drain without refill (out_ready=1, no request): out_valid goes to 0 next cycle. out_data and out_sel hold their last value.
- Back-pressure: while out_valid && !out_ready, out_data and out_sel are stable and every in_ready is 0.
- Simultaneous drain and refill in one cycle: the new word is loaded with no bubble, giving full throughput of 1 word/cycle.
- Channel requests may drop without a transfer. The arbiter is memoryless apart from the pointer; there is no held grant (except as set out under Optional Feature).
- Reset mid-operation: the buffered word is discarded and the pointer returns to 0.

Optional Feature:
- Macro: ARB_LOCK_EN.
- When defined, an extra input port in_lock (N bits) exists.
  - If channel g transfers with in_lock[g]=1, the grant is locked to g.
  - While locked, other channels are ignored even if g's in_valid is 0; the block waits.
  - The lock releases after a transfer from g with in_lock[g]=0.
  - Lock state resets to unlocked.
  - The round-robin pointer does not advance while locked; it advances on the releasing beat.
- When not defined: the in_lock port is absent and arbitration is per-cycle as described under Behaviour.

Decomposition:
- arb_pkg:
  - typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_t.
  - function for clog2-safe index width: returns 1 when N=2.
- Sub-module rr_arbiter (N, MODE): in_valid, pointer and advance-enable in; one-hot grant and encoded index out.
- The pointer register lives inside rr_arbiter. The data mux and output register live in arb_mux_n.

Test Plan:
All scenarios use N=4, W=8.
- Reset: assert reset_n=0 mid-transfer with out_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0 immediately; first post-reset grant with all valid goes to channel 0.
- Round-robin fairness: all 4 channels valid constantly, out_ready=1, data 8'hA0..A3 -> out_sel sequence 0,1,2,3,0,... with one word per cycle and no bubbles.
- Fixed priority (MODE=ARB_FIXED): channels 1 and 3 valid -> channel 1 served every cycle; channel 3 in_ready stays 0 until channel 1 drops.
- Back-pressure: out_valid=1, out_data=8'h5C, out_ready=0 for 5 cycles with channel 2 valid -> out_data stays 8'h5C and in_ready=4'b0000; on out_ready=1, channel 2 is accepted and appears the next cycle.
- Wrap and sparse requests: pointer=3, only channel 0 valid -> grant 0, pointer becomes 1; then only channel 3 valid -> grant 3, pointer becomes 0.
- ARB_LOCK_EN: channel 1 sends 3 beats with in_lock=1,1,0 while channel 0 is valid -> channel 0 gets no in_ready until after the third beat; the next grant is channel 2 if valid, else channel 0.
